sha256_padder: RTL

//  Message padder and block builder directly upstream of the SHA-256 engine. Accepts a byte-packed
//  32-bit word stream from the SHA-256 input FIFO and builds 512-bit blocks. Appends the 0x80 byte,

---
 rtl/sha256_padder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sha256_padder.sv
// sha256_padder: builds padded 512-bit SHA-256 blocks from a 32-bit word stream (define SHA256_PADDER_LE_EN for byte-swapped input); ports: s_* word stream in, eng_ready_i/start_o/vec_o/final_o engine handshake, done_o end-of-message pulse
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  input  logic         s_last,
  input  logic [2:0]   s_bytes,
  output logic         s_ready,
  input  logic         eng_ready_i,
  output logic         start_o,
  output logic [511:0] vec_o,
  output logic         final_o,
  output logic         done_o
);
  typedef enum logic [2:0] {FILL, PAD, LEN, SEND, WAIT} state_t;
  state_t state;
  logic [4:0] widx;
  logic [3:0] wn;
  logic [LEN_W-1:0] cnt, add;
  logic busy_seen, second, pad80, full;
  logic [31:0] din, tail;
  logic [4:0] sh;
  logic [63:0] len;
`ifdef SHA256_PADDER_LE_EN
  assign din = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
  assign din = s_data;
`endif
  assign full = s_bytes[2];
  assign sh = {s_bytes[1:0], 3'b000};
  assign tail = (din & ~(32'hFFFFFFFF >> sh)) | (32'h80000000 >> sh);
  assign add = LEN_W'((s_last && !full) ? {s_bytes, 3'b000} : 6'd32);
  assign len = 64'(cnt);
  assign wn = widx[3:0] + 4'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      widx <= '0;
      cnt <= '0;
      busy_seen <= 1'b0;
      second <= 1'b0;
      pad80 <= 1'b0;
      s_ready <= 1'b0;
      start_o <= 1'b0;
      vec_o <= '0;
      final_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      start_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            cnt <= cnt + add;
            if (!s_last) begin
              vec_o[{~widx[3:0], 5'b0} +: 32] <= din;
              widx <= widx + 5'd1;
              if (widx == 5'd15) begin
                s_ready <= 1'b0;
                state <= SEND;
              end
            end else begin
              s_ready <= 1'b0;
              if (!full) begin
                vec_o[{~widx[3:0], 5'b0} +: 32] <= tail;
                widx <= widx + 5'd1;
                state <= PAD;
              end else begin
                vec_o[{~widx[3:0], 5'b0} +: 32] <= din;
                if (widx == 5'd15) begin
                  // 0x80 word spills into word 0 of the next block
                  pad80 <= 1'b1;
                  second <= 1'b1;
                  state <= SEND;
                end else begin
                  vec_o[{~wn, 5'b0} +: 32] <= 32'h80000000;
                  widx <= widx + 5'd2;
                  state <= PAD;
                end
              end
            end
          end
        end
        PAD: begin
          if (widx == 5'd14) state <= LEN;
          else if (widx == 5'd16) begin
            // no room for the length: ship this block and pad another
            second <= 1'b1;
            state <= SEND;
          end else begin
            vec_o[{~widx[3:0], 5'b0} +: 32] <= 32'h0;
            widx <= widx + 5'd1;
          end
        end
        LEN: begin
          vec_o[63:0] <= len;
          final_o <= 1'b1;
          state <= SEND;
        end
        SEND: begin
          busy_seen <= 1'b0;
          if (eng_ready_i) begin
            start_o <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!eng_ready_i) busy_seen <= 1'b1;
          else if (busy_seen) begin
            vec_o <= pad80 ? {32'h80000000, 480'b0} : '0;
            widx <= pad80 ? 5'd1 : 5'd0;
            pad80 <= 1'b0;
            if (final_o) begin
              done_o <= 1'b1;
              cnt <= '0;
              final_o <= 1'b0;
              s_ready <= 1'b1;
              state <= FILL;
            end else if (second) begin
              second <= 1'b0;
              state <= PAD;
            end else begin
              s_ready <= 1'b1;
              state <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule
